// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - fixed data-first priority select with instruction starvation override
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                    i_req,
  input  logic                    d_req,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output logic                    gnt_i,
  output logic                    gnt_d
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic starved;

  // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
  always_comb begin
    starved = (starve_cnt >= STARVE_LIM);
    gnt_d   = d_req && !(i_req && starved);
    gnt_i   = i_req && !gnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [STARVE_CNT_W-1:0] CNT_SAT = '1;

  arb_state_e              state;
  arb_owner_e              owner;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    sel_i;
  logic                    sel_d;
  logic                    resp_hit;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .gnt_i      (sel_i),
    .gnt_d      (sel_d)
  );

  always_comb begin
    i_gnt = (state == IDLE) && sel_i;
    d_gnt = (state == IDLE) && sel_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_i) begin
            state      <= ISSUE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
          end else if (sel_d) begin
            state   <= ISSUE;
            owner   <= OWN_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (i_req && (starve_cnt != CNT_SAT)) begin
              starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          if (m_gnt) begin
            state <= WAIT;
            m_req <= 1'b0;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

  // Responses outside WAIT are stray and never reach a requester.
  always_comb begin
    resp_hit = (state == WAIT) && m_rvalid;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    if (resp_hit && (owner == OWN_I)) begin
      i_rvalid = 1'b1;
      i_rdata  = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
    end else if (resp_hit && (owner == OWN_D)) begin
      d_rvalid = 1'b1;
      d_rdata  = m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the unified memory port arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt = 1'b0;
  logic              m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  // memory model: 64-bit words, gnt after gnt_delay stalled cycles, rvalid rv_delay+1 cycles after gnt
  logic [63:0] mem [logic [63:0]];
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          hold_cnt  = 0;
  bit          rv_pend   = 1'b0;
  int          rv_wait   = 0;
  bit          force_rv  = 1'b0;
  logic [63:0] rv_data   = '0;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    logic [63:0] k;
    k = a >> 3;
    if (mem.exists(k)) return mem[k];
    return {a[31:0] ^ 32'h5A5A_5A5A, a[31:0]};
  endfunction

  always begin
    @(posedge clk);
    #1;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    if (force_rv) begin
      m_rvalid = 1'b1;
      m_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      force_rv = 1'b0;
    end else if (rv_pend) begin
      if (rv_wait == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = rv_data;
        rv_pend  = 1'b0;
      end else begin
        rv_wait--;
      end
    end
    if (m_req === 1'b1) begin
      if (hold_cnt >= gnt_delay) begin
        m_gnt    = 1'b1;
        hold_cnt = 0;
        if (m_we) begin
          mem[m_addr >> 3] = m_wdata;
          rv_data = '0;
        end else begin
          rv_data = mem_rd(m_addr);
        end
        rv_pend = 1'b1;
        rv_wait = rv_delay;
      end else begin
        hold_cnt++;
      end
    end
  end

  // scoreboard: expectation pushed at grant, popped at the matching rvalid
  typedef struct packed {
    logic        we;
    logic [63:0] data;
  } d_exp_t;

  logic [31:0] exp_i [$];
  d_exp_t      exp_d [$];
  logic [63:0] mon_w;
  logic [31:0] mon_ie;
  d_exp_t      mon_de;

  always @(negedge clk) begin
    if (!rst) begin
      if (i_gnt || d_gnt) begin
        checks++;
        if (i_gnt && d_gnt) begin
          errors++;
          $display("FAIL onehot_gnt: i_gnt=%0b d_gnt=%0b, required at most one", i_gnt, d_gnt);
        end
      end
      if (i_gnt) begin
        mon_w = mem_rd(i_addr);
        exp_i.push_back(i_addr[2] ? mon_w[63:32] : mon_w[31:0]);
      end
      if (d_gnt) exp_d.push_back({d_we, d_we ? 64'h0 : mem_rd(d_addr)});
      if (i_rvalid) begin
        checks++;
        if (exp_i.size() == 0) begin
          errors++;
          $display("FAIL sb_i_unexpected: i_rvalid=1 rdata=%h, required no pulse", i_rdata);
        end else begin
          mon_ie = exp_i.pop_front();
          if (i_rdata !== mon_ie) begin
            errors++;
            $display("FAIL sb_i_rdata: got %h, required %h", i_rdata, mon_ie);
          end
        end
      end
      if (d_rvalid) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL sb_d_unexpected: d_rvalid=1 rdata=%h, required no pulse", d_rdata);
        end else begin
          mon_de = exp_d.pop_front();
          if (!mon_de.we && (d_rdata !== mon_de.data)) begin
            errors++;
            $display("FAIL sb_d_rdata: got %h, required %h", d_rdata, mon_de.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt/rvalid/m_req/m_we=%b, required 000000",
               {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we});
    end
    checks++;
    if ({m_addr, m_wdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_mbus: m_addr=%h m_wdata=%h, required 0", m_addr, m_wdata);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h, required 0", i_rdata, d_rdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_ifetch();
    mem[64'h1004 >> 3] = 64'hAABBCCDD_11223344;
    gnt_delay = 0;
    rv_delay  = 0;
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 64'h1004;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_gnt: i_gnt=%b d_gnt=%b, required 1 0", i_gnt, d_gnt);
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || m_addr !== 64'h1004 || m_we !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_issue: m_req=%b m_addr=%h m_we=%b, required 1 1004 0", m_req, m_addr, m_we);
    end
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hAABBCCDD || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_resp: i_rvalid=%b i_rdata=%h d_rvalid=%b, required 1 aabbccdd 0",
               i_rvalid, i_rdata, d_rvalid);
    end
  endtask

  task automatic test_write_stall();
    gnt_delay = 3;
    @(posedge clk);
    #1;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h2000;
    d_wdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
      errors++;
      $display("FAIL write_gnt: d_gnt=%b i_gnt=%b, required 1 0", d_gnt, i_gnt);
    end
    @(posedge clk);
    #1;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 64'h2000 || m_wdata !== 64'hDEADBEEF_CAFEF00D
          || d_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL write_hold[%0d]: m_req=%b m_we=%b m_addr=%h m_wdata=%h d_rvalid=%b, required 1 1 2000 deadbeefcafef00d 0",
                 c, m_req, m_we, m_addr, m_wdata, d_rvalid);
      end
    end
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: d_rvalid=%b m_req=%b, required 1 0", d_rvalid, m_req);
    end
    gnt_delay = 0;
  endtask

  task automatic test_data_read();
    @(posedge clk);
    #1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h2000;
    @(negedge clk);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 64'hDEADBEEF_CAFEF00D || i_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_back: d_rvalid=%b d_rdata=%h i_rvalid=%b, required 1 deadbeefcafef00d 0",
               d_rvalid, d_rdata, i_rvalid);
    end
  endtask

  task automatic test_priority();
    string exp_s;
    byte   got [10];
    int    n;
    int    cyc;
    exp_s = "DDDDIDDDDI";
    n     = 0;
    cyc   = 0;
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 64'h3008;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h4000;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (d_gnt) begin
        got[n] = "D";
        n++;
      end else if (i_gnt) begin
        got[n] = "I";
        n++;
      end
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL prio_count: got %0d grants in %0d cycles, required 10", n, cyc);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] != exp_s[k]) begin
        errors++;
        $display("FAIL prio_order[%0d]: got %c, required %c", k, got[k], exp_s[k]);
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL prio_drain: %0d i and %0d d responses outstanding, required 0",
               exp_i.size(), exp_d.size());
    end
  endtask

  task automatic test_spurious_rv();
    int pulses;
    pulses = 0;
    mem[64'h1000 >> 3] = 64'h0000_0001_0000_0013;
    gnt_delay = 2;
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 64'h1000;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL spur_gnt: i_gnt=%b, required 1", i_gnt);
    end
    force_rv = 1'b1;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_req !== 1'b1) begin
      errors++;
      $display("FAIL spur_issue: i_rvalid=%b d_rvalid=%b m_req=%b, required 0 0 1", i_rvalid, d_rvalid, m_req);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_rvalid === 1'b1) begin
        pulses++;
        checks++;
        if (i_rdata !== 32'h0000_0013) begin
          errors++;
          $display("FAIL spur_rdata: i_rdata=%h, required 00000013", i_rdata);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL spur_pulses: got %0d i_rvalid pulses, required 1", pulses);
    end
    gnt_delay = 0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    rv_delay = 1;
    @(posedge clk);
    #1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h2000;
    @(negedge clk);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we} !== 6'b0 || {m_addr, m_wdata} !== 128'h0
        || {i_rdata, d_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: ctrl=%b m_addr=%h d_rdata=%h, required all 0",
               {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we}, m_addr, d_rdata);
    end
    exp_i.delete();
    exp_d.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rv_delay = 0;
    d_req    = 1'b1;
    d_addr   = 64'h2000;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_regrant: d_gnt=%b, required 1", d_gnt);
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
    seen  = 1'b0;
    cyc   = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (d_rvalid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (d_rdata !== 64'hDEADBEEF_CAFEF00D) begin
          errors++;
          $display("FAIL rstmid_rdata: d_rdata=%h, required deadbeefcafef00d", d_rdata);
        end
      end
    end
    checks++;
    if (!seen || cyc != 2) begin
      errors++;
      $display("FAIL rstmid_latency: seen=%0b after %0d cycles, required 1 after 2", seen, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ifetch();
    test_write_stall();
    test_data_read();
    test_priority();
    test_spurious_rv();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d i and %0d d responses outstanding, required 0",
               exp_i.size(), exp_d.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
